cache_data_ram_p: RTL and testbench

Parametrised single-port synchronous data RAM for the instruction/data cache and TCM paths, the successor to the fixed 64-bit × 1024 cache data array. Adds configurable width and depth, per-byte write enables, a read-first or write-first collision mode, an optional output pipeline register, a read-valid strobe, and a built-in clear sequencer. The clear sequencer zeroes the whole array after reset or on request, with `ready_o` as back-pressure. Sits directly under the cache/TCM controllers, replacing their private data arrays.

---
 rtl/cache_data_ram_p_pkg.sv | 20 ++
 rtl/cache_data_ram_p_core.sv | 60 ++++++
 rtl/cache_data_ram_p.sv | 180 ++++++++++++++++++
 tb/tb_cache_data_ram_p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_data_ram_p_pkg.sv
// -----------------------------------------------------------------------------
// cache_data_ram_p_pkg
// Shared definitions for the parametrised cache/TCM data RAM: the collision-mode
// constants and the clear-sequencer state encoding. Controllers that instantiate
// cache_data_ram_p can import this package to pick a mode by name.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_data_ram_p_pkg;

    // Collision mode: what a read returns when the same access also writes.
    localparam logic RAM_READ_FIRST  = 1'b0;   // old word
    localparam logic RAM_WRITE_FIRST = 1'b1;   // merged new word

    // Clear sequencer states.
    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

endpackage : cache_data_ram_p_pkg

// File: rtl/cache_data_ram_p_core.sv
// -----------------------------------------------------------------------------
// ram_sp_be_core
// Single-port storage array with per-byte write enables and a synchronous read
// register whose content on a colliding write is chosen by WRITE_FIRST.
// No reset: neither the array nor the read register is initialised here.
// Ports:
//   clk_i    in  1          clock
//   en_i     in  1          array access this cycle (read and/or write)
//   rd_en_i  in  1          capture the read word into rdata_o
//   addr_i   in  ADDR_W     word address
//   data_i   in  DATA_W     write data
//   be_i     in  DATA_W/8   byte write enables
//   rdata_o  out DATA_W     registered read data (holds when rd_en_i is low)
// -----------------------------------------------------------------------------
module ram_sp_be_core
    import cache_data_ram_p_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 10,
    parameter int WRITE_FIRST = 0
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o
);

    localparam int   NB    = DATA_W / 8;
    localparam int   DEPTH = 1 << ADDR_W;
    localparam logic WF    = (WRITE_FIRST != 0) ? RAM_WRITE_FIRST : RAM_READ_FIRST;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-wise write and mode-selected read capture on the same port.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
                if (rd_en_i) begin
                    // Write-first forwards written bytes; untouched bytes
                    // (and all bytes in read-first) come from the array.
                    if (be_i[b] && (WF == RAM_WRITE_FIRST)) begin
                        rdata_q[8*b +: 8] <= data_i[8*b +: 8];
                    end else begin
                        rdata_q[8*b +: 8] <= mem_q[addr_i][8*b +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule : ram_sp_be_core

// File: rtl/cache_data_ram_p.sv
// -----------------------------------------------------------------------------
// cache_data_ram_p
// Parametrised single-port cache/TCM data RAM. Wraps ram_sp_be_core with a
// clear sequencer (zero fill after reset and on request), request gating,
// an optional output pipeline register and a read-valid strobe.
// Ports:
//   clk_i    in  1          clock, rising edge
//   rst_i    in  1          synchronous active-high reset
//   req_i    in  1          access request, accepted when req_i && ready_o
//   addr_i   in  ADDR_W     word address
//   data_i   in  DATA_W     write data
//   wr_i     in  DATA_W/8   byte write enables (all zero = pure read)
//   clear_i  in  1          start a full-array zero fill (from IDLE)
//   data_o   out DATA_W     read data, holds between reads, 0 after reset
//   valid_o  out 1          one-cycle strobe per accepted access
//   ready_o  out 1          registered, high only in IDLE
// -----------------------------------------------------------------------------
module cache_data_ram_p
    import cache_data_ram_p_pkg::*;
#(
    parameter int DATA_W        = 64,
    parameter int ADDR_W        = 10,
    parameter int WRITE_FIRST   = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W/8-1:0]   wr_i,
    input  logic                  clear_i,
    output logic [DATA_W-1:0]     data_o,
    output logic                  valid_o,
    output logic                  ready_o
);

    localparam int          NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam clr_state_e  RST_STATE = (INIT_ON_RESET != 0) ? CLR_CLEAR : CLR_IDLE;
    localparam logic        RST_READY = (INIT_ON_RESET != 0) ? 1'b0 : 1'b1;

    clr_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic               ready_q, ready_d;
    logic               s1_valid_q;
    logic               rd_seen_q;

    logic               accept_s;
    logic               clearing_s;
    logic               core_en_s;
    logic [ADDR_W-1:0]  core_addr_s;
    logic [DATA_W-1:0]  core_wdata_s;
    logic [NB-1:0]      core_be_s;
    logic [DATA_W-1:0]  core_rdata_s;
    logic [DATA_W-1:0]  s1_data_s;

    // Clear FSM state register, clear counter and registered ready.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= {ADDR_W{1'b0}};
            ready_q   <= RST_READY;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Clear FSM next-state logic; clear_i is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE: begin
                if (clear_i) begin
                    state_d = CLR_CLEAR;
                end else begin
                    state_d = CLR_IDLE;
                end
            end
            CLR_CLEAR: begin
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = CLR_IDLE;
                end else begin
                    state_d = CLR_CLEAR;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // FSM outputs: counter advance, ready, and muxing of clear writes onto the core.
    always_comb begin
        clr_cnt_d    = {ADDR_W{1'b0}};
        ready_d      = (state_d == CLR_IDLE);
        // Nothing touches the array on a reset cycle, so a reset discards any
        // access presented alongside it.
        clearing_s   = (state_q == CLR_CLEAR) && !rst_i;
        accept_s     = req_i && ready_q && !rst_i;
        core_en_s    = accept_s || clearing_s;
        core_addr_s  = addr_i;
        core_wdata_s = data_i;
        core_be_s    = wr_i;
        if (state_q == CLR_CLEAR) begin
            // No wrap past the last address: IDLE resets the counter to 0.
            clr_cnt_d = clr_cnt_q + ADDR_W'(1'b1);
        end else begin
            clr_cnt_d = {ADDR_W{1'b0}};
        end
        if (clearing_s) begin
            core_addr_s  = clr_cnt_q;
            core_wdata_s = {DATA_W{1'b0}};
            core_be_s    = {NB{1'b1}};
        end else begin
            core_addr_s  = addr_i;
            core_wdata_s = data_i;
            core_be_s    = wr_i;
        end
    end

    ram_sp_be_core #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WRITE_FIRST (WRITE_FIRST)
    ) u_core (
        .clk_i   (clk_i),
        .en_i    (core_en_s),
        .rd_en_i (accept_s),
        .addr_i  (core_addr_s),
        .data_i  (core_wdata_s),
        .be_i    (core_be_s),
        .rdata_o (core_rdata_s)
    );

    // Stage-1 valid strobe and the flag that unmasks the (unreset) core read register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            s1_valid_q <= accept_s;
            rd_seen_q  <= rd_seen_q | accept_s;
        end
    end

    // The core read register has no reset; present zero until the first read
    // after reset has landed in it.
    assign s1_data_s = rd_seen_q ? core_rdata_s : {DATA_W{1'b0}};

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] data_q;
            logic              valid_q;

            // Output pipeline stage; advances every cycle, no stalls.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_q  <= {DATA_W{1'b0}};
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= s1_data_s;
                    valid_q <= s1_valid_q;
                end
            end

            assign data_o  = data_q;
            assign valid_o = valid_q;
        end else begin : g_no_out_reg
            assign data_o  = s1_data_s;
            assign valid_o = s1_valid_q;
        end
    endgenerate

    assign ready_o = ready_q;

endmodule : cache_data_ram_p

// File: tb/tb_cache_data_ram_p.sv
// -----------------------------------------------------------------------------
// tb_cache_data_ram_p
// Directed bench for cache_data_ram_p. Three instances share one stimulus:
//   A: read-first, no output register (L=1), clear on reset
//   B: write-first, output register (L=2), clear on reset
//   C: no clear on reset (only its reset-time ready is examined)
// Inputs change #1 after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_cache_data_ram_p;

    logic        clk;
    logic        rst;
    logic        req;
    logic [3:0]  addr;
    logic [63:0] wdata;
    logic [7:0]  wr;
    logic        clr;

    logic [63:0] a_data, b_data, c_data;
    logic        a_valid, b_valid, c_valid;
    logic        a_ready, b_ready, c_ready;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] vals [8];

    cache_data_ram_p #(.DATA_W(64), .ADDR_W(4), .WRITE_FIRST(0), .OUT_REG(0), .INIT_ON_RESET(1)) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(wdata), .wr_i(wr),
        .clear_i(clr), .data_o(a_data), .valid_o(a_valid), .ready_o(a_ready));

    cache_data_ram_p #(.DATA_W(64), .ADDR_W(4), .WRITE_FIRST(1), .OUT_REG(1), .INIT_ON_RESET(1)) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(wdata), .wr_i(wr),
        .clear_i(clr), .data_o(b_data), .valid_o(b_valid), .ready_o(b_ready));

    cache_data_ram_p #(.DATA_W(64), .ADDR_W(4), .WRITE_FIRST(0), .OUT_REG(0), .INIT_ON_RESET(0)) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .data_i(wdata), .wr_i(wr),
        .clear_i(clr), .data_o(c_data), .valid_o(c_valid), .ready_o(c_ready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access, then an idle cycle; A result after 1 edge, B result after 2.
    task automatic do_acc(input logic [3:0] a, input logic [63:0] d, input logic [7:0] w,
                          input logic [63:0] exp_a, input logic [63:0] exp_b, input string tag);
        req = 1'b1; addr = a; wdata = d; wr = w;
        tick();
        req = 1'b0; wr = 8'h00;
        chk({tag, "_a_valid"}, 64'(a_valid), 64'd1);
        chk({tag, "_a_data"},  a_data, exp_a);
        chk({tag, "_b_pipe"},  64'(b_valid), 64'd0);
        tick();
        chk({tag, "_b_valid"}, 64'(b_valid), 64'd1);
        chk({tag, "_b_data"},  b_data, exp_b);
        chk({tag, "_a_hold"},  a_data, exp_a);
        chk({tag, "_a_strobe"}, 64'(a_valid), 64'd0);
    endtask

    // Count cycles with ready low (current sample included), bounded.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!a_ready && n < 40) begin
            n++;
            tick();
        end
        chk(tag, 64'(n), 64'd16);
        chk({tag, "_b_ready"}, 64'(b_ready), 64'd1);
    endtask

    initial begin
        int n;
        int nv;
        rst = 1'b1; req = 1'b0; addr = 4'd0; wdata = 64'd0; wr = 8'h00; clr = 1'b0;
        tick();
        tick();
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_a_valid", 64'(a_valid), 64'd0);
        chk("rst_a_data",  a_data, 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_b_data",  b_data, 64'd0);
        chk("rst_c_ready", 64'(c_ready), 64'd1);
        rst = 1'b0;
        wait_ready("reset_clear_len");

        // Every word is zero after the reset clear.
        for (int i = 0; i < 16; i++) begin
            do_acc(4'(i), 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 64'd0, "clr_rd");
        end

        // Fill 0..7, then read them back to back.
        for (int k = 0; k < 8; k++) begin
            vals[k] = 64'h0101_0101_0101_0101 * 64'(k + 1);
            do_acc(4'(k), vals[k], 8'hFF, 64'd0, vals[k], "fill");
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                req = 1'b1; addr = 4'(k); wr = 8'h00;
            end else begin
                req = 1'b0;
            end
            tick();
            if (k < 8) begin
                chk("burst_a_valid", 64'(a_valid), 64'd1);
                chk("burst_a_data",  a_data, vals[k]);
            end else begin
                chk("burst_a_idle", 64'(a_valid), 64'd0);
            end
            if (k >= 1 && k <= 8) begin
                chk("burst_b_valid", 64'(b_valid), 64'd1);
                chk("burst_b_data",  b_data, vals[k-1]);
            end else begin
                chk("burst_b_idle", 64'(b_valid), 64'd0);
            end
        end
        req = 1'b0;

        // Byte enables.
        do_acc(4'd3, 64'h1122_3344_5566_7788, 8'hFF, vals[3], 64'h1122_3344_5566_7788, "be_full");
        do_acc(4'd3, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'h1122_3344_5566_7788, 64'h1122_3344_AAAA_AAAA, "be_low");
        do_acc(4'd3, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, 64'h1122_3344_AAAA_AAAA, "be_rd");

        // Collision mode.
        do_acc(4'd5, 64'd1, 8'hFF, vals[5], 64'd1, "col_w1");
        do_acc(4'd5, 64'd2, 8'hFF, 64'd1, 64'd2, "col_w2");
        do_acc(4'd5, 64'd0, 8'h00, 64'd2, 64'd2, "col_rd");

        // Write then read of the same address on consecutive cycles.
        req = 1'b1; addr = 4'd5; wdata = 64'd3; wr = 8'hFF;
        tick();
        chk("b2b_w_a", a_data, 64'd2);
        wr = 8'h00;
        tick();
        chk("b2b_r_a", a_data, 64'd3);
        chk("b2b_w_b", b_data, 64'd3);
        req = 1'b0;
        tick();
        chk("b2b_r_b_valid", 64'(b_valid), 64'd1);
        chk("b2b_r_b", b_data, 64'd3);
        chk("b2b_a_idle", 64'(a_valid), 64'd0);

        // Clear together with a read; req and clear_i held through CLEAR.
        do_acc(4'd2, 64'h55, 8'hFF, vals[2], 64'h55, "pre_clr");
        req = 1'b1; addr = 4'd2; wr = 8'h00; clr = 1'b1;
        tick();
        chk("clr_rd_a_valid", 64'(a_valid), 64'd1);
        chk("clr_rd_a_data",  a_data, 64'h55);
        chk("clr_ready_fall", 64'(a_ready), 64'd0);
        n = 0;
        nv = 0;
        while (!a_ready && n < 40) begin
            n++;
            tick();
            if (n == 1) begin
                chk("clr_rd_b_valid", 64'(b_valid), 64'd1);
                chk("clr_rd_b_data",  b_data, 64'h55);
            end
            if (a_valid) begin
                nv++;
            end
        end
        req = 1'b0; clr = 1'b0;
        chk("clr_len_held", 64'(n), 64'd16);
        chk("clr_no_accept", 64'(nv), 64'd0);
        do_acc(4'd2, 64'd0, 8'h00, 64'd0, 64'd0, "post_clr");

        // Reset on cycle 7 of a clear.
        do_acc(4'd1, 64'hDEAD, 8'hFF, 64'd0, 64'hDEAD, "pre_rst");
        req = 1'b1; addr = 4'd1; wr = 8'h00; clr = 1'b1;
        tick();
        req = 1'b0; clr = 1'b0;
        chk("mid_rd_a", a_data, 64'hDEAD);
        tick();
        chk("mid_rd_b", b_data, 64'hDEAD);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("mid_a_hold", a_data, 64'hDEAD);
        rst = 1'b1;
        tick();
        chk("mid_rst_a_data",  a_data, 64'd0);
        chk("mid_rst_b_data",  b_data, 64'd0);
        chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
        chk("mid_rst_b_valid", 64'(b_valid), 64'd0);
        rst = 1'b0;
        wait_ready("mid_rst_clear_len");

        // Reset with a read still in B's output pipeline.
        do_acc(4'd1, 64'hBEEF, 8'hFF, 64'd0, 64'hBEEF, "fly_w");
        req = 1'b1; addr = 4'd1; wr = 8'h00;
        tick();
        chk("fly_a_data", a_data, 64'hBEEF);
        req = 1'b0; rst = 1'b1;
        tick();
        chk("fly_b_valid", 64'(b_valid), 64'd0);
        chk("fly_b_data",  b_data, 64'd0);
        chk("fly_a_data_rst", a_data, 64'd0);
        rst = 1'b0;
        wait_ready("fly_clear_len");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_cache_data_ram_p
